mux_sel_arbiter: RTL and testbench

- Round-robin arbiter that shares one nbit_mux-style selection resource among 2**SELECT_WIDTH requesters.
- Drives the MuxSel lines of the shared mux and returns a one-hot grant to the winner.
- A grant is held until the owner drops its request or a hold-limit timeout fires.
- Sits between the multicycle control unit's requesters and the shared datapath mux.

---
 rtl/mux_sel_arbiter.sv | 132 +++++++++++++
 tb/tb_mux_sel_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter for a shared mux select resource: one-hot grant plus binary
// MuxSel, with grant held until the owner releases or a hold-limit timeout revokes it.
module mux_sel_arbiter #(
  parameter int unsigned SELECT_WIDTH = 3,
  parameter int unsigned MAX_HOLD     = 16,
  parameter int unsigned HOLD_WIDTH   = 16,
  localparam int unsigned N           = 2**SELECT_WIDTH
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic [N-1:0]            Req,
  output logic [N-1:0]            Grant,
  output logic [SELECT_WIDTH-1:0] MuxSel,
  output logic                    GrantValid,
  output logic                    Timeout
);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t                  r_state, w_state_nx;
  logic [N-1:0]            r_grant, w_grant_nx;
  logic [SELECT_WIDTH-1:0] r_sel, w_sel_nx;
  logic [SELECT_WIDTH-1:0] r_ptr, w_ptr_nx;
  logic [HOLD_WIDTH-1:0]   r_hold, w_hold_nx;
  logic                    r_valid, w_valid_nx;
  logic                    r_timeout, w_timeout_nx;

  logic [SELECT_WIDTH-1:0] w_base;
  logic [SELECT_WIDTH-1:0] w_idx;
  logic [SELECT_WIDTH-1:0] w_win;
  logic                    w_found;
  logic [N-1:0]            w_req_m;
  logic [N-1:0]            w_win_onehot;
  logic                    w_owner_req;
  logic                    w_hold_max;

  // Round-robin search starting after the base; the current owner is masked out
  // so that a timeout never re-selects it while someone else is waiting.
  always_comb begin
    w_base  = (r_state == ST_OWNED) ? r_sel : r_ptr;
    w_req_m = Req;
    if (r_state == ST_OWNED) w_req_m[r_sel] = 1'b0;
    w_idx   = '0;
    w_win   = '0;
    w_found = 1'b0;
    for (int i = N; i >= 1; i--) begin
      w_idx = w_base + SELECT_WIDTH'(i);
      if (w_req_m[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_win_onehot = N'(1) << w_win;
  assign w_owner_req  = Req[r_sel];
  assign w_hold_max   = (r_hold == HOLD_WIDTH'(MAX_HOLD - 1));

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_sel_nx     = r_sel;
    w_ptr_nx     = r_ptr;
    w_hold_nx    = r_hold;
    w_valid_nx   = r_valid;
    w_timeout_nx = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant_nx = w_win_onehot;
          w_sel_nx   = w_win;
          w_valid_nx = 1'b1;
          w_hold_nx  = '0;
          w_state_nx = ST_OWNED;
        end
      end
      ST_OWNED: begin
        if (!w_owner_req) begin
          w_ptr_nx = r_sel;
          if (w_found) begin
            w_grant_nx = w_win_onehot;
            w_sel_nx   = w_win;
            w_hold_nx  = '0;
          end else begin
            w_grant_nx = '0;
            w_valid_nx = 1'b0;
            w_hold_nx  = '0;
            w_state_nx = ST_IDLE;
          end
        end else if (w_hold_max) begin
          w_ptr_nx     = r_sel;
          w_timeout_nx = 1'b1;
          w_hold_nx    = '0;
          if (w_found) begin
            w_grant_nx = w_win_onehot;
            w_sel_nx   = w_win;
          end
        end else begin
          w_hold_nx = r_hold + HOLD_WIDTH'(1);
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_grant   <= '0;
      r_sel     <= '0;
      r_ptr     <= SELECT_WIDTH'(N - 1);
      r_hold    <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_sel     <= w_sel_nx;
      r_ptr     <= w_ptr_nx;
      r_hold    <= w_hold_nx;
      r_valid   <= w_valid_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  assign Grant      = r_grant;
  assign MuxSel     = r_sel;
  assign GrantValid = r_valid;
  assign Timeout    = r_timeout;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter (MAX_HOLD=4): ownership-level reference model compared
// every cycle, plus directed scenarios with literal expected values.
module tb_mux_sel_arbiter;

  localparam int unsigned SW  = 3;
  localparam int unsigned N   = 8;
  localparam int unsigned MH  = 4;

  logic          Clk;
  logic          Reset_n;
  logic [N-1:0]  Req;
  logic [N-1:0]  Grant;
  logic [SW-1:0] MuxSel;
  logic          GrantValid;
  logic          Timeout;

  int n_checks = 0;
  int n_errors = 0;

  mux_sel_arbiter #(.SELECT_WIDTH(SW), .MAX_HOLD(MH), .HOLD_WIDTH(16)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Grant(Grant),
    .MuxSel(MuxSel), .GrantValid(GrantValid), .Timeout(Timeout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks who owns the resource and for how many cycles.
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_held  = 0;
  int m_sel   = 0;
  bit m_tout  = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int start, input int excl);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_owner = -1; m_ptr = N - 1; m_held = 0; m_sel = 0; m_tout = 1'b0;
    end else begin
      m_tout = 1'b0;
      if (m_owner < 0) begin
        m_owner = pick(Req, m_ptr, -1);
        m_held  = 1;
      end else if (!Req[m_owner]) begin
        m_ptr   = m_owner;
        m_owner = pick(Req, m_ptr, -1);
        m_held  = 1;
      end else if (m_held == MH) begin
        int w;
        m_tout = 1'b1;
        m_ptr  = m_owner;
        w      = pick(Req, m_owner, m_owner);
        if (w >= 0) m_owner = w;
        m_held = 1;
      end else begin
        m_held++;
      end
      if (m_owner >= 0) m_sel = m_owner;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    logic [N-1:0] eg;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("model_grant", 32'(Grant), 32'(eg));
    chk("model_muxsel", 32'(MuxSel), 32'(m_sel));
    chk("model_valid", 32'(GrantValid), 32'(m_owner >= 0));
    chk("model_timeout", 32'(Timeout), 32'(m_tout));
    chk("onehot0_grant", 32'($onehot0(Grant)), 32'd1);
  end

  task automatic do_reset();
    @(negedge Clk); Reset_n = 1'b0;
    @(negedge Clk); Reset_n = 1'b1;
  endtask

  task automatic edge_chk(input string nm, input logic [N-1:0] g, input int sel,
                          input bit v, input bit t);
    @(posedge Clk); #1;
    chk({nm, "_grant"}, 32'(Grant), 32'(g));
    chk({nm, "_sel"}, 32'(MuxSel), 32'(sel));
    chk({nm, "_valid"}, 32'(GrantValid), 32'(v));
    chk({nm, "_tout"}, 32'(Timeout), 32'(t));
  endtask

  initial begin
    Reset_n = 1'b1;
    Req     = '0;
    #1 Reset_n = 1'b0;
    #1;
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_sel", 32'(MuxSel), 32'd0);
    chk("rst_valid", 32'(GrantValid), 32'd0);
    chk("rst_tout", 32'(Timeout), 32'd0);
    @(negedge Clk); Reset_n = 1'b1;

    // Single requester 2.
    @(negedge Clk); Req = 8'b0000_0100;
    edge_chk("t1_grant", 8'b0000_0100, 2, 1'b1, 1'b0);
    @(negedge Clk); Req = 8'b0000_0000;
    edge_chk("t1_idle", 8'b0000_0000, 2, 1'b0, 1'b0);

    // Gapless handover 0 -> 7, then idle holding MuxSel.
    do_reset();
    @(negedge Clk); Req = 8'b1000_0001;
    edge_chk("t2_g0", 8'b0000_0001, 0, 1'b1, 1'b0);
    @(negedge Clk); Req = 8'b1000_0000;
    edge_chk("t2_g7", 8'b1000_0000, 7, 1'b1, 1'b0);
    @(negedge Clk); Req = 8'b0000_0000;
    edge_chk("t2_idle", 8'b0000_0000, 7, 1'b0, 1'b0);

    // Two persistent requesters alternate every MAX_HOLD cycles.
    @(negedge Clk); Req = 8'b0000_0011;
    for (int c = 0; c < 16; c++) begin
      int o;
      o = (c / 4) % 2;
      edge_chk("t3_rot", 8'(1 << o), o, 1'b1, (c > 0) && (c % 4 == 0));
    end
    @(negedge Clk); Req = 8'b0000_0000;
    edge_chk("t3_idle", 8'b0000_0000, 1, 1'b0, 1'b0);

    // Lone requester 5 re-granted on every timeout.
    @(negedge Clk); Req = 8'b0010_0000;
    for (int c = 0; c <= 12; c++)
      edge_chk("t4_hold", 8'b0010_0000, 5, 1'b1, (c > 0) && (c % 4 == 0));
    @(negedge Clk); Req = 8'b0000_0000;
    edge_chk("t4_idle", 8'b0000_0000, 5, 1'b0, 1'b0);

    // Release coincides with hold limit: no Timeout pulse.
    @(negedge Clk); Req = 8'b0000_1000;
    edge_chk("t5_g3", 8'b0000_1000, 3, 1'b1, 1'b0);
    @(negedge Clk); Req = 8'b0100_1000;
    @(posedge Clk);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk); Req = 8'b0100_0000;
    edge_chk("t5_g6", 8'b0100_0000, 6, 1'b1, 1'b0);

    // Asynchronous reset mid-grant, then all requesters.
    @(negedge Clk); Req = 8'b0000_0100;
    edge_chk("t6_g2", 8'b0000_0100, 2, 1'b1, 1'b0);
    #3 Reset_n = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(Grant), 32'd0);
    chk("t6_rst_sel", 32'(MuxSel), 32'd0);
    chk("t6_rst_valid", 32'(GrantValid), 32'd0);
    chk("t6_rst_tout", 32'(Timeout), 32'd0);
    @(negedge Clk); Req = 8'b1111_1111; Reset_n = 1'b1;
    edge_chk("t6_g0", 8'b0000_0001, 0, 1'b1, 1'b0);
    repeat (10) @(posedge Clk);
    @(negedge Clk); Req = 8'b0000_0000;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
